// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter.
// Two line buffers plus a 3x3 window feed a gradient stage with |Gx|, |Gy|,
// |Gx|+|Gy| or passthrough selection, output saturation, optional binary
// thresholding and zeroed borders. Stage one is the window and the per-beat
// control; stage two is the registered output. oDVAL follows each accepted
// beat by two cycles.
module sobel_stream_filter #(
    parameter int DATA_W = 12,
    parameter int IMG_W  = 1280,
    parameter int IMG_H  = 960
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iGREY,
    input  logic              iDVAL,
    input  logic              iSOF,
    input  logic [1:0]        iMODE,
    input  logic              iTHR_EN,
    input  logic [DATA_W-1:0] iTHRESH,
    output logic [DATA_W-1:0] oPIX,
    output logic              oDVAL,
    output logic              oSOF
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int GW = DATA_W + 3;   // signed gradient width
    localparam int SW = DATA_W + 4;   // width of |Gx|+|Gy| and the mode mux

    localparam logic [CW-1:0]     COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]     ROW_LAST = RW'(IMG_H - 1);
    localparam logic [DATA_W-1:0] PIX_MAX  = {DATA_W{1'b1}};

    // Zero-extend a pixel into the signed gradient width.
    function automatic logic signed [GW-1:0] ext_f(input logic [DATA_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    // Magnitude of a signed gradient; it never exceeds 4*(2^DATA_W-1).
    function automatic logic [GW-2:0] abs_f(input logic signed [GW-1:0] v);
        logic signed [GW-1:0] mag;
        mag = v[GW-1] ? -v : v;
        return mag[GW-2:0];
    endfunction

    // Clamp to the largest representable pixel value.
    function automatic logic [DATA_W-1:0] sat_f(input logic [SW-1:0] v);
        return (v > {4'b0000, PIX_MAX}) ? PIX_MAX : v[DATA_W-1:0];
    endfunction

    // Line buffers: lb1 holds line r-1, lb2 holds line r-2. Not reset; stale
    // contents only ever reach bordered outputs.
    logic [DATA_W-1:0] lb1_r [0:IMG_W-1];
    logic [DATA_W-1:0] lb2_r [0:IMG_W-1];

    logic [CW-1:0] col_r, col_eff_s, col_nxt_s;
    logic [RW-1:0] row_r, row_eff_s, row_nxt_s;
    logic          border_s;
    logic [DATA_W-1:0] lb1_rd_s, lb2_rd_s;

    // 3x3 window: t/m/b = rows r-2/r-1/r, l/m/r = oldest..newest column
    logic [DATA_W-1:0] tl_r, tm_r, tr_r, ml_r, mm_r, mr_r, bl_r, bm_r, br_r;

    logic              s1_vld_r, s1_sof_r, s1_border_r, s1_thr_en_r;
    logic [1:0]        s1_mode_r;
    logic [DATA_W-1:0] s1_thresh_r;

    logic signed [GW-1:0] gx_s, gy_s;
    logic [GW-2:0]        ax_s, ay_s;
    logic [SW-1:0]        sel_s;
    logic [DATA_W-1:0]    sat_s, res_s;

    assign lb1_rd_s = lb1_r[col_eff_s];
    assign lb2_rd_s = lb2_r[col_eff_s];

    // Position of the current beat (iSOF forces 0,0) and the next position.
    always_comb begin
        col_eff_s = iSOF ? {CW{1'b0}} : col_r;
        row_eff_s = iSOF ? {RW{1'b0}} : row_r;
        col_nxt_s = col_eff_s;
        row_nxt_s = row_eff_s;
        if (col_eff_s == COL_LAST) begin
            col_nxt_s = {CW{1'b0}};
            if (row_eff_s == ROW_LAST) begin
                row_nxt_s = {RW{1'b0}};
            end else begin
                row_nxt_s = row_eff_s + RW'(1);
            end
        end else begin
            col_nxt_s = col_eff_s + CW'(1);
            row_nxt_s = row_eff_s;
        end
        border_s = (col_eff_s < CW'(2)) || (row_eff_s < RW'(2));
    end

    // Column/row counters advance only on accepted beats.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            col_r <= {CW{1'b0}};
            row_r <= {RW{1'b0}};
        end else if (iDVAL) begin
            col_r <= col_nxt_s;
            row_r <= row_nxt_s;
        end
    end

    // Line buffer write: each column shifts one line older.
    always_ff @(posedge iCLK) begin
        if (iDVAL) begin
            lb2_r[col_eff_s] <= lb1_rd_s;
            lb1_r[col_eff_s] <= iGREY;
        end
    end

    // Window shift: new column enters on the right.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            tl_r <= '0; tm_r <= '0; tr_r <= '0;
            ml_r <= '0; mm_r <= '0; mr_r <= '0;
            bl_r <= '0; bm_r <= '0; br_r <= '0;
        end else if (iDVAL) begin
            tl_r <= tm_r; tm_r <= tr_r; tr_r <= lb2_rd_s;
            ml_r <= mm_r; mm_r <= mr_r; mr_r <= lb1_rd_s;
            bl_r <= bm_r; bm_r <= br_r; br_r <= iGREY;
        end
    end

    // Per-beat control travels alongside the window contents.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            s1_vld_r    <= 1'b0;
            s1_sof_r    <= 1'b0;
            s1_border_r <= 1'b1;
            s1_mode_r   <= 2'd0;
            s1_thr_en_r <= 1'b0;
            s1_thresh_r <= {DATA_W{1'b0}};
        end else begin
            s1_vld_r <= iDVAL;
            if (iDVAL) begin
                s1_sof_r    <= iSOF;
                s1_border_r <= border_s;
                s1_mode_r   <= iMODE;
                s1_thr_en_r <= iTHR_EN;
                s1_thresh_r <= iTHRESH;
            end
        end
    end

    // Gradients, mode select, saturation, threshold and border masking.
    always_comb begin
        gx_s = (ext_f(tr_r) + ext_f(mr_r) + ext_f(mr_r) + ext_f(br_r))
             - (ext_f(tl_r) + ext_f(ml_r) + ext_f(ml_r) + ext_f(bl_r));
        gy_s = (ext_f(bl_r) + ext_f(bm_r) + ext_f(bm_r) + ext_f(br_r))
             - (ext_f(tl_r) + ext_f(tm_r) + ext_f(tm_r) + ext_f(tr_r));
        ax_s = abs_f(gx_s);
        ay_s = abs_f(gy_s);
        case (s1_mode_r)
            2'd0:    sel_s = {2'b00, ax_s};
            2'd1:    sel_s = {2'b00, ay_s};
            2'd2:    sel_s = {2'b00, ax_s} + {2'b00, ay_s};
            2'd3:    sel_s = {4'b0000, mm_r};
            default: sel_s = {SW{1'b0}};
        endcase
        sat_s = sat_f(sel_s);
        if (s1_border_r) begin
            res_s = {DATA_W{1'b0}};
        end else if (s1_thr_en_r) begin
            res_s = (sat_s >= s1_thresh_r) ? PIX_MAX : {DATA_W{1'b0}};
        end else begin
            res_s = sat_s;
        end
    end

    // Registered outputs; pixel and SOF are forced low when not valid.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oPIX  <= {DATA_W{1'b0}};
            oDVAL <= 1'b0;
            oSOF  <= 1'b0;
        end else begin
            oDVAL <= s1_vld_r;
            oPIX  <= s1_vld_r ? res_s : {DATA_W{1'b0}};
            oSOF  <= s1_vld_r & s1_sof_r;
        end
    end

endmodule
